lmfe_pix_src: RTL and testbench



---
 rtl/lmfe_pkg.sv | 25 ++
 rtl/lmfe_src_fifo.sv | 71 +++++++
 rtl/lmfe_pix_src.sv | 163 ++++++++++++++++
 tb/tb_lmfe_pix_src.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmfe_pkg.sv
// ---------------------------------------------------------------------------
// lmfe_pkg
// Shared definitions for the local median filter engine pixel source:
//   - default frame geometry (IMG_W_DEF, IMG_H_DEF, N_PIX_DEF)
//   - the frame streamer state enum (IDLE, RUN, DONE)
//   - read-ahead FIFO depth and the width of its occupancy counter
// ---------------------------------------------------------------------------
package lmfe_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int IMG_H_DEF  = 128;
  localparam int N_PIX_DEF  = IMG_W_DEF * IMG_H_DEF;

  // The read-ahead FIFO holds up to FIFO_DEPTH pixels. The counter needs
  // one extra bit so that "full" (4) is distinguishable from "empty" (0).
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } src_state_e;

endpackage

// File: rtl/lmfe_src_fifo.sv
// ---------------------------------------------------------------------------
// lmfe_src_fifo
// FIFO_DEPTH x DATA_W synchronous FIFO with registered storage, a
// combinational head and an occupancy count.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (storage cleared to 0)
//   wr_en_i    in   push wr_data_i this cycle
//   wr_data_i  in   data to push
//   rd_en_i    in   pop the head this cycle
//   rd_data_o  out  current head entry (stable while nothing is popped)
//   count_o    out  number of entries held
// The caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module lmfe_src_fifo
  import lmfe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic [FIFO_CNT_W-1:0] count_d;

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too, so the head (and therefore Din) reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/lmfe_pix_src.sv
// ---------------------------------------------------------------------------
// lmfe_pix_src
// Frame streamer feeding the median filter's Din/in_en input. On start it
// reads one IMG_W x IMG_H frame in raster order from a synchronous-read
// SRAM, buffers up to FIFO_DEPTH pixels, and sends them while busy is low.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle frame request, honoured only in IDLE
//   mem_rd     out  SRAM read strobe
//   mem_addr   out  SRAM read address
//   mem_rdata  in   SRAM read data, valid the cycle after mem_rd
//   busy       in   filter back-pressure
//   Din        out  pixel to filter (FIFO head)
//   in_en      out  pixel valid; a transfer happens on every edge with in_en=1
//   active     out  frame in progress (RUN or DONE)
//   done       out  one-cycle pulse after the last transfer
//   chksum     out  (LMFE_SRC_CHKSUM_EN only) mod-2^16 sum of transferred Din
// Optional feature macro: LMFE_SRC_CHKSUM_EN
// ---------------------------------------------------------------------------
module lmfe_pix_src
  import lmfe_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              busy,
  output logic [DATA_W-1:0] Din,
  output logic              in_en,
  output logic              active,
  output logic              done
`ifdef LMFE_SRC_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);

  // Counters are one bit wider than the address so that N_PIX itself is
  // representable when the frame exactly fills the address space.
  localparam int              N_PIX_I  = IMG_W * IMG_H;
  localparam logic [ADDR_W:0] N_PIX    = N_PIX_I[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_PIX = N_PIX - 1'b1;
  localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);

  src_state_e            state_q;
  src_state_e            state_d;
  logic [ADDR_W:0]       addr_q;
  logic [ADDR_W:0]       addr_d;
  logic [ADDR_W:0]       sent_q;
  logic [ADDR_W:0]       sent_d;
  logic                  inflight_q;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W-1:0] occupancy;
  logic [DATA_W-1:0]     fifo_head;
  logic                  start_ok;

  lmfe_src_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (inflight_q),
    .wr_data_i (mem_rdata),
    .rd_en_i   (in_en),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count)
  );

  // Reads already in the SRAM pipeline count against FIFO space, so the
  // FIFO can never overflow. Only registered terms feed mem_rd: busy must
  // not reach the SRAM strobe combinationally.
  assign occupancy = fifo_count + {{(FIFO_CNT_W-1){1'b0}}, inflight_q};
  assign mem_rd    = (state_q == RUN) && (addr_q < N_PIX) && (occupancy < DEPTH_C);
  assign mem_addr  = addr_q[ADDR_W-1:0];

  assign in_en     = (state_q == RUN) && (fifo_count != '0) && !busy;
  assign Din       = fifo_head;
  assign active    = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign start_ok  = (state_q == IDLE) && start;

  // Next-state logic: a start accepted in IDLE restarts both counters from 0;
  // the edge carrying the final transfer moves to the single DONE cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sent_d  = sent_q;
    if (mem_rd) begin
      addr_d = addr_q + 1'b1;
    end
    if (in_en) begin
      sent_d = sent_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          addr_d  = '0;
          sent_d  = '0;
        end
      end
      RUN: begin
        if (in_en && (sent_q == LAST_PIX)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sent_q     <= sent_d;
      inflight_q <= mem_rd;
    end
  end

`ifdef LMFE_SRC_CHKSUM_EN
  logic [15:0] chksum_q;
  logic [15:0] chksum_d;

  // No transfers happen outside RUN, so the sum holds from DONE until the
  // next accepted start clears it.
  always_comb begin
    chksum_d = chksum_q;
    if (start_ok) begin
      chksum_d = '0;
    end else if (in_en) begin
      chksum_d = chksum_q + 16'(Din);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chksum_q <= '0;
    end else begin
      chksum_q <= chksum_d;
    end
  end

  assign chksum = chksum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_lmfe_pix_src.sv
// ---------------------------------------------------------------------------
// tb_lmfe_pix_src
// Directed bench for lmfe_pix_src with a synchronous-read SRAM model.
// Optional feature macro: LMFE_SRC_CHKSUM_EN (adds the checksum test).
// ---------------------------------------------------------------------------
module tb_lmfe_pix_src;

  localparam int N_PIX = 16384;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [7:0]  Din;
  logic        in_en;
  logic        active;
  logic        done;
`ifdef LMFE_SRC_CHKSUM_EN
  logic [15:0] chksum;
`endif

  int n_checks;
  int n_fail;
  int pat;

  // Statistics gathered by the monitor, cleared at each frame start.
  int cyc, iss, snt, addr_err, occ_err, busy_err, ord_err, first_bad;
  int first_rd_c, first_c, last_c, done_c, done_n, max_out;
  int resume_c, resume_in_en;
  logic [7:0] first_din, last_din;

  lmfe_pix_src dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .Din       (Din),
    .in_en     (in_en),
    .active    (active),
    .done      (done)
`ifdef LMFE_SRC_CHKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  // Pattern 0 is a[7:0]; pattern 1 mixes high address bits in and is
  // nonzero at address 0 so it cannot be confused with reset data.
  function automatic logic [7:0] pix(input int a, input int p);
    logic [13:0] aa;
    aa = a[13:0];
    if (p == 0) return aa[7:0];
    return (aa[7:0] ^ aa[13:6]) + 8'h5A;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: data for the address strobed in one cycle appears the next.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= pix(int'(mem_addr), pat);
  end

  task automatic clear_stats();
    cyc = 0; iss = 0; snt = 0; addr_err = 0; occ_err = 0; busy_err = 0;
    ord_err = 0; first_bad = -1; first_rd_c = -1; first_c = -1; last_c = -1;
    done_c = -1; done_n = 0; max_out = 0; resume_c = -1; resume_in_en = 0;
    first_din = 8'h00; last_din = 8'h00;
  endtask

  // Monitor: samples at the falling edge, tracks issued reads and transfers
  // and records addressing, occupancy, ordering and back-pressure violations.
  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        if (first_rd_c < 0) first_rd_c = cyc;
        if (mem_addr !== iss[13:0]) addr_err++;
        if ((iss - snt) >= 4) occ_err++;
        iss++;
      end
      if (in_en) begin
        if (busy) busy_err++;
        if (Din !== pix(snt, pat)) begin
          if (ord_err == 0) first_bad = snt;
          ord_err++;
        end
        if (snt == 0) begin
          first_c = cyc;
          first_din = Din;
        end
        last_c = cyc;
        last_din = Din;
        snt++;
      end
      if (cyc == resume_c) resume_in_en = int'(in_en);
      if ((iss - snt) > max_out) max_out = iss - snt;
      if (done) begin
        done_n++;
        done_c = cyc;
      end
      cyc++;
    end
  end

  // Cycle 0 is the cycle in which start is high; returns early in cycle 1.
  task automatic start_frame();
    @(posedge clk); #1;
    clear_stats();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: busy low; mode 1: random busy; mode 2: busy high in cycles
  // 1000..1019 plus a stray start pulse in cycle 50.
  task automatic run_until_done(input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      case (mode)
        1: busy = 1'($urandom_range(0, 1));
        2: begin
          busy  = (cyc >= 1000) && (cyc < 1020);
          start = (cyc == 50);
        end
        default: busy = 1'b0;
      endcase
      @(negedge clk); #1;
      if (done_n != 0) ok = 1'b1;
    end
    busy  = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    n_checks++; if (mem_addr !== 14'd0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
    n_checks++; if (Din !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_Din: got %h expected 00", Din); end
    n_checks++; if (in_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_en: got %b expected 0", in_en); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
`ifdef LMFE_SRC_CHKSUM_EN
    n_checks++; if (chksum !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_chksum: got %h expected 0000", chksum); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stream();
    bit ok;
    pat = 0;
    start_frame();
    run_until_done(20000, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_done_seen: got %0d expected 1", ok); end
    n_checks++; if (first_rd_c !== 1) begin n_fail++; $display("[TB] FAIL stream_first_rd_cycle: got %0d expected 1", first_rd_c); end
    n_checks++; if (first_c !== 3) begin n_fail++; $display("[TB] FAIL stream_first_in_en_cycle: got %0d expected 3", first_c); end
    n_checks++; if (first_din !== 8'h00) begin n_fail++; $display("[TB] FAIL stream_first_Din: got %h expected 00", first_din); end
    n_checks++; if (last_c !== 16386) begin n_fail++; $display("[TB] FAIL stream_last_in_en_cycle: got %0d expected 16386", last_c); end
    n_checks++; if (last_din !== 8'hFF) begin n_fail++; $display("[TB] FAIL stream_last_Din: got %h expected FF", last_din); end
    n_checks++; if (done_c !== 16387) begin n_fail++; $display("[TB] FAIL stream_done_cycle: got %0d expected 16387", done_c); end
    n_checks++; if (snt !== N_PIX) begin n_fail++; $display("[TB] FAIL stream_count: got %0d expected %0d", snt, N_PIX); end
    n_checks++; if (ord_err !== 0) begin n_fail++; $display("[TB] FAIL stream_order: got %0d bad pixels (first %0d) expected 0", ord_err, first_bad); end
    n_checks++; if (addr_err !== 0) begin n_fail++; $display("[TB] FAIL stream_addr_seq: got %0d errors expected 0", addr_err); end
    @(negedge clk); #1;
    n_checks++; if (done_n !== 1) begin n_fail++; $display("[TB] FAIL stream_done_width: got %0d cycles expected 1", done_n); end
    n_checks++; if (in_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_no_extra_transfer: got %b expected 0", in_en); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_idle_active: got %b expected 0", active); end
  endtask

`ifdef LMFE_SRC_CHKSUM_EN
  task automatic test_chksum();
    n_checks++; if (chksum !== 16'hE000) begin n_fail++; $display("[TB] FAIL chksum_value: got %h expected E000", chksum); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (chksum !== 16'hE000) begin n_fail++; $display("[TB] FAIL chksum_held: got %h expected E000", chksum); end
  endtask
`endif

  task automatic test_reset_midframe();
    bit ok;
    bit hit;
    pat = 1;
    start_frame();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk); #1;
      if (snt == 100) hit = 1'b1;
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_reach_100: got %0d expected 1", hit); end
    n_checks++; if (in_en !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_streaming_before: got %b expected 1", in_en); end
    reset = 1'b1;
    #1;
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_mem_rd: got %b expected 0", mem_rd); end
    n_checks++; if (mem_addr !== 14'd0) begin n_fail++; $display("[TB] FAIL midreset_mem_addr: got %0d expected 0", mem_addr); end
    n_checks++; if (Din !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_Din: got %h expected 00", Din); end
    n_checks++; if (in_en !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_in_en: got %b expected 0", in_en); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_active: got %b expected 0", active); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    // Restarted frame runs under random 50% back-pressure.
    start_frame();
    run_until_done(40000, 1, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL random_done_seen: got %0d expected 1", ok); end
    n_checks++; if (first_din !== 8'h5A) begin n_fail++; $display("[TB] FAIL random_first_Din: got %h expected 5A", first_din); end
    n_checks++; if (snt !== N_PIX) begin n_fail++; $display("[TB] FAIL random_count: got %0d expected %0d", snt, N_PIX); end
    n_checks++; if (ord_err !== 0) begin n_fail++; $display("[TB] FAIL random_order: got %0d bad pixels (first %0d) expected 0", ord_err, first_bad); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("[TB] FAIL random_in_en_while_busy: got %0d expected 0", busy_err); end
    n_checks++; if (occ_err !== 0) begin n_fail++; $display("[TB] FAIL random_overissue: got %0d expected 0", occ_err); end
    n_checks++; if (addr_err !== 0) begin n_fail++; $display("[TB] FAIL random_addr_seq: got %0d errors expected 0", addr_err); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    pat = 1;
    start_frame();
    resume_c = 1020;
    run_until_done(20000, 2, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_done_seen: got %0d expected 1", ok); end
    n_checks++; if (max_out !== 4) begin n_fail++; $display("[TB] FAIL hold_max_outstanding: got %0d expected 4", max_out); end
    n_checks++; if (occ_err !== 0) begin n_fail++; $display("[TB] FAIL hold_overissue: got %0d expected 0", occ_err); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("[TB] FAIL hold_in_en_while_busy: got %0d expected 0", busy_err); end
    n_checks++; if (resume_in_en !== 1) begin n_fail++; $display("[TB] FAIL hold_resume: got %0d expected 1", resume_in_en); end
    n_checks++; if (ord_err !== 0) begin n_fail++; $display("[TB] FAIL hold_order: got %0d bad pixels (first %0d) expected 0", ord_err, first_bad); end
    n_checks++; if (snt !== N_PIX) begin n_fail++; $display("[TB] FAIL hold_count: got %0d expected %0d", snt, N_PIX); end
    n_checks++; if (last_c !== 16406) begin n_fail++; $display("[TB] FAIL hold_last_cycle: got %0d expected 16406", last_c); end
    n_checks++; if (done_c !== 16407) begin n_fail++; $display("[TB] FAIL hold_done_cycle: got %0d expected 16407", done_c); end
  endtask

  // Must follow a frame whose DONE cycle has just been sampled.
  task automatic test_restart_after_done();
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_idle_active: got %b expected 0", active); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_idle_mem_rd: got %b expected 0", mem_rd); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_mem_rd: got %b expected 1", mem_rd); end
    n_checks++; if (mem_addr !== 14'd0) begin n_fail++; $display("[TB] FAIL restart_mem_addr: got %0d expected 0", mem_addr); end
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_active: got %b expected 1", active); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pat      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    busy     = 1'b0;
    test_reset();
    test_stream();
`ifdef LMFE_SRC_CHKSUM_EN
    test_chksum();
`endif
    test_reset_midframe();
    test_busy_hold();
    test_restart_after_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
